writeback_stage: RTL and testbench
==================================

# writeback_stage

MEM/WB pipeline register and write-back stage of the five-stage MIPS core. It captures the retiring instruction from the memory stage and performs sub-word load extraction and sign/zero extension. It selects the write-back source and drives the register file's write port (WriteEn, rdAddress, Write_Back). It also keeps a count of retired instructions.

## Interface
Parameters:
- DATA_W, 32, datapath width (only 32 is supported)
- ADDR_W, 5, register address width

Ports:
- clk  in  1  core clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- stall  in  1  hold the MEM/WB register contents
- flush  in  1  load a bubble into MEM/WB; has priority over stall
- mem_valid  in  1  memory stage holds a real instruction
- mem_RegWrite  in  1  instruction writes a register
- mem_WbSel  in  2  00 ALU result, 01 load data, 10 link address, 11 treated as 00
- mem_LoadType  in  3  000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu, 101–111 treated as lw
- mem_ALUResult  in  32  ALU result; bits [1:0] are the load byte offset
- mem_ReadData  in  32  raw data-memory word
- mem_LinkAddr  in  32  return address for jal/jalr
- mem_rd  in  5  destination register
- WriteEn  out  1  register-file write enable
- rdAddress  out  5  register-file write address
- Write_Back  out  32  register-file write data
- wb_valid  out  1  WB register holds a real instruction
- instret  out  32  retired-instruction counter

## Operation
- MEM/WB register fields: valid, RegWrite, WbSel, LoadType, ALUResult, ReadData, LinkAddr, rd.
- Register update priority at each rising edge:
  - flush: valid←0 and RegWrite←0; other fields don't-care.
  - else stall: hold all fields.
  - else: load all mem_* inputs.
- Load extraction, combinational from registered fields, little-endian, off = ALUResult[1:0]:
  - lb / lbu: byte ReadData[8·off+7 : 8·off], sign- / zero-extended to 32.
  - lh / lhu: halfword ReadData[16·off[1]+15 : 16·off[1]], sign- / zero-extended; off[0] ignored, no misalignment trap.
  - lw: ReadData unchanged; off ignored.
- Write_Back is the value selected by WbSel.
- rdAddress = registered rd.
- WriteEn = valid & RegWrite & (rd ≠ 0). Register $0 is never written.
- While stalled, WriteEn stays asserted with the same address and data. The repeated writes are idempotent.
- instret:
  - Increments by 1 on each rising edge where wb_valid=1 and (stall=0 or flush=1), i.e. the instruction leaves WB.
  - Wraps from 0xFFFFFFFF to 0.
  - Bubbles and invalid entries do not count.

## Timing
- Instruction present on mem_* in cycle n (not stalled or flushed) appears on WriteEn, rdAddress and Write_Back in cycle n+1. The register file commits it at the end of cycle n+1.
- Outputs are combinational from registered state only; there is no input-to-output combinational path.
- Reset (asynchronous assert, any cycle, including mid-stall) forces:
  - all MEM/WB fields to 0;
  - instret to 0;
  - WriteEn=0, wb_valid=0, rdAddress=0, Write_Back=0.
- First capture happens at the first rising edge after reset deasserts.
- stall and flush together: flush wins. The bubble is loaded and the outgoing valid instruction is counted.

## Structure
- Shared core package holds:
  - WbSel encodings: WB_ALU, WB_MEM, WB_LINK;
  - LoadType encodings: LD_W, LD_B, LD_BU, LD_H, LD_HU;
  - REG_ZERO constant.
- Natural sub-module: load_extract, a combinational unit taking ReadData, offset and LoadType and returning the 32-bit extended value.
- Register, mux and counter stay in writeback_stage.

## Test plan
- Reset mid-operation:
  - Assert reset while wb_valid=1 and instret=7 → WriteEn=0, Write_Back=0, instret=0 immediately, without waiting for a clock edge.
- Load extraction with ReadData=0x80F1_7F02:
  - lb off=3 → 0xFFFFFF80
  - lbu off=3 → 0x00000080
  - lh off=2 → 0xFFFF80F1
  - lhu off=1 → 0x00007F02
  - lw off=2 → 0x80F17F02
- ALU and link sources with rd=0:
  - ALU op, rd=5, result 0x1234 → next cycle WriteEn=1, rdAddress=5, Write_Back=0x1234.
  - jal, LinkAddr=0x0040_0008, rd=31 → Write_Back=0x00400008.
  - rd=0, RegWrite=1 → WriteEn=0 while wb_valid=1.
- Stall:
  - Stall 3 cycles with an instruction in WB → outputs held constant, instret unchanged.
  - Release stall → instret +1 and the new instruction is captured.
- Flush with stall:
  - flush and stall together with a valid instruction in WB → next cycle wb_valid=0, WriteEn=0, instret +1.
- Counter wrap:
  - Preload instret to 0xFFFFFFFF via a stream of valid instructions (or force it) → one more retirement gives instret=0.

Source files
------------

// File: rtl/writeback_stage_pkg.sv
// Shared core definitions for the write-back stage: source select and
// load-type encodings, the hard-wired zero register and extension helpers.
package writeback_stage_pkg;

  // Write-back source select
  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_LINK = 2'b10;

  // Load type encodings; unlisted codes behave as a full-word load
  localparam logic [2:0] LD_W  = 3'b000;
  localparam logic [2:0] LD_B  = 3'b001;
  localparam logic [2:0] LD_BU = 3'b010;
  localparam logic [2:0] LD_H  = 3'b011;
  localparam logic [2:0] LD_HU = 3'b100;

  // Register $0 reads as zero and is never written
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Sign- or zero-extend a byte to 32 bits
  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic is_signed);
    ext_byte = {{24{is_signed & b[7]}}, b};
  endfunction

  // Sign- or zero-extend a halfword to 32 bits
  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic is_signed);
    ext_half = {{16{is_signed & h[15]}}, h};
  endfunction

endpackage

// File: rtl/writeback_stage_load_extract.sv
// Combinational sub-word load extraction (little-endian) with sign/zero
// extension. Halfword loads use only offset bit 1; no misalignment trap.
module writeback_stage_load_extract
  import writeback_stage_pkg::*;
(
  input  logic [31:0] i_read_data,
  input  logic [1:0]  i_offset,
  input  logic [2:0]  i_load_type,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Pick the addressed byte and halfword out of the memory word
  always_comb begin
    w_byte = 8'h00;
    case (i_offset)
      2'd0:    w_byte = i_read_data[7:0];
      2'd1:    w_byte = i_read_data[15:8];
      2'd2:    w_byte = i_read_data[23:16];
      2'd3:    w_byte = i_read_data[31:24];
      default: w_byte = i_read_data[7:0];
    endcase
    if (i_offset[1]) begin
      w_half = i_read_data[31:16];
    end else begin
      w_half = i_read_data[15:0];
    end
  end

  // Extend the selected piece according to the load type
  always_comb begin
    o_data = i_read_data;
    case (i_load_type)
      LD_B:    o_data = ext_byte(w_byte, 1'b1);
      LD_BU:   o_data = ext_byte(w_byte, 1'b0);
      LD_H:    o_data = ext_half(w_half, 1'b1);
      LD_HU:   o_data = ext_half(w_half, 1'b0);
      default: o_data = i_read_data;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and write-back stage: captures the retiring
// instruction, extracts load data, drives the register-file write port and
// counts retired instructions.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              mem_valid,
  input  logic              mem_RegWrite,
  input  logic [1:0]        mem_WbSel,
  input  logic [2:0]        mem_LoadType,
  input  logic [DATA_W-1:0] mem_ALUResult,
  input  logic [DATA_W-1:0] mem_ReadData,
  input  logic [DATA_W-1:0] mem_LinkAddr,
  input  logic [ADDR_W-1:0] mem_rd,
  output logic              WriteEn,
  output logic [ADDR_W-1:0] rdAddress,
  output logic [DATA_W-1:0] Write_Back,
  output logic              wb_valid,
  output logic [31:0]       instret
);

  logic              r_valid;
  logic              r_reg_write;
  logic [1:0]        r_wb_sel;
  logic [2:0]        r_load_type;
  logic [DATA_W-1:0] r_alu_result;
  logic [DATA_W-1:0] r_read_data;
  logic [DATA_W-1:0] r_link_addr;
  logic [ADDR_W-1:0] r_rd;
  logic [31:0]       r_instret;
  logic [DATA_W-1:0] w_load_data;
  logic              w_retire;

  // An instruction leaves WB when the register is not held, or is flushed
  assign w_retire = r_valid & (~stall | flush);

  // MEM/WB register: flush beats stall, stall holds, otherwise capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_wb_sel     <= 2'b00;
      r_load_type  <= 3'b000;
      r_alu_result <= '0;
      r_read_data  <= '0;
      r_link_addr  <= '0;
      r_rd         <= '0;
    end else if (flush) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
    end else if (!stall) begin
      r_valid      <= mem_valid;
      r_reg_write  <= mem_RegWrite;
      r_wb_sel     <= mem_WbSel;
      r_load_type  <= mem_LoadType;
      r_alu_result <= mem_ALUResult;
      r_read_data  <= mem_ReadData;
      r_link_addr  <= mem_LinkAddr;
      r_rd         <= mem_rd;
    end else begin
      r_valid      <= r_valid;
      r_reg_write  <= r_reg_write;
    end
  end

  // Retired-instruction counter, wraps naturally at 2^32
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_instret <= 32'd0;
    end else if (w_retire) begin
      r_instret <= r_instret + 32'd1;
    end else begin
      r_instret <= r_instret;
    end
  end

  writeback_stage_load_extract u_load_extract (
    .i_read_data (r_read_data),
    .i_offset    (r_alu_result[1:0]),
    .i_load_type (r_load_type),
    .o_data      (w_load_data)
  );

  // Write-back source mux; the unused select code falls back to the ALU
  always_comb begin
    Write_Back = r_alu_result;
    case (r_wb_sel)
      WB_MEM:  Write_Back = w_load_data;
      WB_LINK: Write_Back = r_link_addr;
      default: Write_Back = r_alu_result;
    endcase
  end

  // Register-file port; $0 is never written. Stalled writes simply repeat.
  assign WriteEn   = r_valid & r_reg_write & (r_rd != ADDR_W'(REG_ZERO));
  assign rdAddress = r_rd;
  assign wb_valid  = r_valid;
  assign instret   = r_instret;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios plus a
// randomized run compared against a behavioural model of the stage.
module tb_writeback_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        mem_valid;
  logic        mem_RegWrite;
  logic [1:0]  mem_WbSel;
  logic [2:0]  mem_LoadType;
  logic [31:0] mem_ALUResult;
  logic [31:0] mem_ReadData;
  logic [31:0] mem_LinkAddr;
  logic [4:0]  mem_rd;
  logic        WriteEn;
  logic [4:0]  rdAddress;
  logic [31:0] Write_Back;
  logic        wb_valid;
  logic [31:0] instret;

  int n_checks = 0;
  int n_pass   = 0;

  // behavioural model of the WB entry and the counter
  logic        m_valid, m_rw;
  logic [1:0]  m_sel;
  logic [2:0]  m_lt;
  logic [31:0] m_alu, m_rdata, m_link;
  logic [4:0]  m_rd;
  logic [31:0] m_instret;

  writeback_stage #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_RegWrite(mem_RegWrite), .mem_WbSel(mem_WbSel),
    .mem_LoadType(mem_LoadType), .mem_ALUResult(mem_ALUResult),
    .mem_ReadData(mem_ReadData), .mem_LinkAddr(mem_LinkAddr), .mem_rd(mem_rd),
    .WriteEn(WriteEn), .rdAddress(rdAddress), .Write_Back(Write_Back),
    .wb_valid(wb_valid), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected register-file write data for the modelled WB entry
  function automatic logic [31:0] model_wb();
    logic [31:0] v;
    int unsigned off;
    off = int'(m_alu[1:0]);
    if (m_sel == 2'd1) begin
      if (m_lt == 3'd1 || m_lt == 3'd2) begin
        v = (m_rdata >> (8 * off)) & 32'd255;
        if (m_lt == 3'd1 && v >= 32'd128) v = v - 32'd256;
      end else if (m_lt == 3'd3 || m_lt == 3'd4) begin
        v = (m_rdata >> (16 * (off / 2))) & 32'd65535;
        if (m_lt == 3'd3 && v >= 32'd32768) v = v - 32'd65536;
      end else begin
        v = m_rdata;
      end
    end else if (m_sel == 2'd2) begin
      v = m_link;
    end else begin
      v = m_alu;
    end
    return v;
  endfunction

  function automatic logic model_we();
    return m_valid && m_rw && (m_rd != 5'd0);
  endfunction

  task automatic model_clear();
    m_valid = 1'b0; m_rw = 1'b0; m_sel = 2'd0; m_lt = 3'd0;
    m_alu = 32'd0; m_rdata = 32'd0; m_link = 32'd0; m_rd = 5'd0;
    m_instret = 32'd0;
  endtask

  task automatic drive(input logic v, input logic rw, input logic [1:0] sel,
                       input logic [2:0] lt, input logic [31:0] alu,
                       input logic [31:0] rdata, input logic [31:0] link,
                       input logic [4:0] rd);
    mem_valid = v; mem_RegWrite = rw; mem_WbSel = sel; mem_LoadType = lt;
    mem_ALUResult = alu; mem_ReadData = rdata; mem_LinkAddr = link; mem_rd = rd;
  endtask

  // one rising edge: apply the stage rules to the model, then settle to negedge
  task automatic tick();
    @(posedge clk);
    if (m_valid && (!stall || flush)) m_instret = m_instret + 32'd1;
    if (flush) begin
      m_valid = 1'b0; m_rw = 1'b0;
    end else if (!stall) begin
      m_valid = mem_valid; m_rw = mem_RegWrite; m_sel = mem_WbSel;
      m_lt = mem_LoadType; m_alu = mem_ALUResult; m_rdata = mem_ReadData;
      m_link = mem_LinkAddr; m_rd = mem_rd;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(1'b0, 1'b0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 5'd0);
    model_clear();
    @(negedge clk); @(negedge clk);
    n_checks++; if (WriteEn !== 1'b0) $display("FAIL reset_we got %b want 0", WriteEn); else n_pass++;
    n_checks++; if (wb_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", wb_valid); else n_pass++;
    n_checks++; if (rdAddress !== 5'd0) $display("FAIL reset_rd got %0d want 0", rdAddress); else n_pass++;
    n_checks++; if (Write_Back !== 32'd0) $display("FAIL reset_wb got %h want 0", Write_Back); else n_pass++;
    n_checks++; if (instret !== 32'd0) $display("FAIL reset_instret got %h want 0", instret); else n_pass++;
    reset = 1'b1;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 2'd0, 3'd0, 32'h100 + 32'(i), 32'd0, 32'd0, 5'd7);
      tick();
    end
    stall = 1'b1;
    n_checks++; if (instret !== 32'd7 || wb_valid !== 1'b1)
      $display("FAIL pre_reset got instret=%0d valid=%b want 7/1", instret, wb_valid); else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_checks++; if (WriteEn !== 1'b0) $display("FAIL async_reset_we got %b want 0", WriteEn); else n_pass++;
    n_checks++; if (Write_Back !== 32'd0) $display("FAIL async_reset_wb got %h want 0", Write_Back); else n_pass++;
    n_checks++; if (instret !== 32'd0) $display("FAIL async_reset_instret got %h want 0", instret); else n_pass++;
    n_checks++; if (wb_valid !== 1'b0) $display("FAIL async_reset_valid got %b want 0", wb_valid); else n_pass++;
    model_clear();
    @(negedge clk);
    reset = 1'b1; stall = 1'b0;
  endtask

  task automatic test_load_extract();
    logic [2:0]  lts  [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    logic [1:0]  offs [5] = '{2'd3, 2'd3, 2'd2, 2'd1, 2'd2};
    logic [31:0] exps [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80F1, 32'h00007F02, 32'h80F17F02};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 2'd1, lts[i], {30'h1000, offs[i]}, 32'h80F1_7F02, 32'd0, 5'd3);
      tick();
      n_checks++; if (Write_Back !== exps[i])
        $display("FAIL load_extract lt=%0d off=%0d got %h want %h", lts[i], offs[i], Write_Back, exps[i]); else n_pass++;
    end
  endtask

  task automatic test_alu_link();
    drive(1'b1, 1'b1, 2'd0, 3'd0, 32'h1234, 32'hDEAD_BEEF, 32'h0040_0000, 5'd5);
    tick();
    n_checks++; if (WriteEn !== 1'b1 || rdAddress !== 5'd5 || Write_Back !== 32'h1234)
      $display("FAIL alu_write got we=%b rd=%0d wb=%h want 1/5/00001234", WriteEn, rdAddress, Write_Back); else n_pass++;
    drive(1'b1, 1'b1, 2'd2, 3'd0, 32'h5555, 32'd0, 32'h0040_0008, 5'd31);
    tick();
    n_checks++; if (WriteEn !== 1'b1 || rdAddress !== 5'd31 || Write_Back !== 32'h0040_0008)
      $display("FAIL link_write got we=%b rd=%0d wb=%h want 1/31/00400008", WriteEn, rdAddress, Write_Back); else n_pass++;
    drive(1'b1, 1'b1, 2'd0, 3'd0, 32'h77, 32'd0, 32'd0, 5'd0);
    tick();
    n_checks++; if (WriteEn !== 1'b0 || wb_valid !== 1'b1)
      $display("FAIL rd_zero got we=%b valid=%b want 0/1", WriteEn, wb_valid); else n_pass++;
  endtask

  task automatic test_stall();
    logic [31:0] base;
    drive(1'b1, 1'b1, 2'd0, 3'd0, 32'hCAFE_0001, 32'd0, 32'd0, 5'd9);
    tick();
    base = m_instret;
    drive(1'b1, 1'b1, 2'd0, 3'd0, 32'hBEEF_0002, 32'd0, 32'd0, 5'd10);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (WriteEn !== 1'b1 || rdAddress !== 5'd9 || Write_Back !== 32'hCAFE_0001 || instret !== base)
        $display("FAIL stall_hold cyc%0d got we=%b rd=%0d wb=%h instret=%0d want 1/9/cafe0001/%0d",
                 i, WriteEn, rdAddress, Write_Back, instret, base); else n_pass++;
    end
    stall = 1'b0;
    tick();
    n_checks++; if (instret !== base + 32'd1 || rdAddress !== 5'd10 || Write_Back !== 32'hBEEF_0002)
      $display("FAIL stall_release got instret=%0d rd=%0d wb=%h want %0d/10/beef0002",
               instret, rdAddress, Write_Back, base + 32'd1); else n_pass++;
  endtask

  task automatic test_flush_stall();
    logic [31:0] base;
    base = m_instret;
    stall = 1'b1; flush = 1'b1;
    tick();
    n_checks++; if (wb_valid !== 1'b0 || WriteEn !== 1'b0 || instret !== base + 32'd1)
      $display("FAIL flush_stall got valid=%b we=%b instret=%0d want 0/0/%0d",
               wb_valid, WriteEn, instret, base + 32'd1); else n_pass++;
    stall = 1'b0; flush = 1'b0;
    tick();
    n_checks++; if (instret !== base + 32'd1)
      $display("FAIL bubble_count got instret=%0d want %0d", instret, base + 32'd1); else n_pass++;
  endtask

  task automatic test_wrap();
    drive(1'b1, 1'b1, 2'd0, 3'd0, 32'h42, 32'd0, 32'd0, 5'd4);
    tick();
    stall = 1'b1;
    force dut.r_instret = 32'hFFFF_FFFF;
    #1 release dut.r_instret;
    m_instret = 32'hFFFF_FFFF;
    @(negedge clk);
    n_checks++; if (instret !== 32'hFFFF_FFFF)
      $display("FAIL wrap_preload got %h want ffffffff", instret); else n_pass++;
    stall = 1'b0;
    tick();
    n_checks++; if (instret !== 32'd0)
      $display("FAIL wrap got %h want 00000000", instret); else n_pass++;
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 9) == 0);
      drive($urandom_range(0, 4) != 0, 1'($urandom), 2'($urandom), 3'($urandom),
            $urandom, $urandom, $urandom,
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom));
      tick();
      n_checks++;
      if (wb_valid !== m_valid || WriteEn !== model_we() || instret !== m_instret ||
          (m_valid && (rdAddress !== m_rd || Write_Back !== model_wb()))) begin
        if (errs < 10)
          $display("FAIL random cyc%0d got v=%b we=%b rd=%0d wb=%h ir=%0d want v=%b we=%b rd=%0d wb=%h ir=%0d",
                   i, wb_valid, WriteEn, rdAddress, Write_Back, instret,
                   m_valid, model_we(), m_rd, model_wb(), m_instret);
        errs++;
      end else n_pass++;
    end
    stall = 1'b0; flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_load_extract();
    test_alu_link();
    test_stall();
    test_flush_stall();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
